// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// stall-count type and the ID/EX control-mux select values.
package hazard_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StLstall = 2'd1,
        StMwait  = 2'd2
    } hz_state_e;

    // Remaining load-use bubbles; LOAD_USE_STALLS is at most 4, so at most 3 remain.
    typedef logic [1:0] stall_cnt_t;

    localparam logic CTRL_BUBBLE = 1'b0;
    localparam logic CTRL_PASS   = 1'b1;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_memread;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ctrl_mux_sel;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  exmem_write;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_memread, ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, ctrl_mux_sel, ifid_flush, idex_flush, exmem_write, state_o,
               stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_memread, ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, ctrl_mux_sel, ifid_flush, idex_flush, exmem_write, state_o,
               stall_cycles
    );

endinterface

// File: rtl/hazard_ctrl_unit_stall_counter.sv
// Saturating performance counter with enable and synchronous active-high reset.
module hazard_stall_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / memory-wait / branch-flush hazard controller for the 5-stage pipe,
// with multi-cycle load-use stalls and a saturating stall-cycle counter.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned LOAD_USE_STALLS = 1,
    parameter int unsigned IGNORE_R0       = 1,
    parameter int unsigned CNT_W           = 16
) (
    input logic               clk,
    input logic               reset,
    hazard_ctrl_unit_if.slave bus
);

    hz_state_e  state_d, state_q;
    hz_state_e  ret_d, ret_q;
    hz_state_e  eff_state;
    stall_cnt_t cnt_d, cnt_q;
    logic       hz, mw, r0_load;
    logic       pc_write, ifid_write, ctrl_mux_sel, ifid_flush, idex_flush, exmem_write;

    assign mw      = bus.mem_req & ~bus.mem_ready;
    assign r0_load = (IGNORE_R0 != 0) && (bus.ex_rt == REG_ADDR_W'(0));
    assign hz      = bus.ex_memread & ~r0_load &
                     ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));

    // The cycle mem_ready arrives behaves exactly like the state saved on entry to MWAIT.
    always_comb begin
        eff_state = state_q;
        if ((state_q == StMwait) && !mw) begin
            eff_state = ret_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            ret_q   <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = eff_state;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        unique case (eff_state)
            StRun: begin
                if (mw) begin
                    state_d = StMwait;
                    ret_d   = StRun;
                end else if (!bus.ex_branch_taken && hz && (LOAD_USE_STALLS > 1)) begin
                    state_d = StLstall;
                    cnt_d   = stall_cnt_t'(LOAD_USE_STALLS - 1);
                end
            end
            StLstall: begin
                if (mw) begin
                    state_d = StMwait;
                    ret_d   = StLstall;
                end else begin
                    cnt_d = cnt_q - stall_cnt_t'(1);
                    if (cnt_q == stall_cnt_t'(1)) begin
                        state_d = StRun;
                    end
                end
            end
            StMwait: state_d = StMwait;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ctrl_mux_sel = CTRL_PASS;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ctrl_mux_sel = CTRL_BUBBLE;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_write  = 1'b0;
        end else if (mw) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (eff_state == StLstall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ctrl_mux_sel = CTRL_BUBBLE;
        end else if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hz) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ctrl_mux_sel = CTRL_BUBBLE;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.ctrl_mux_sel = ctrl_mux_sel;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_write  = exmem_write;
    assign bus.state_o      = state_q;

    hazard_stall_counter #(
        .CNT_W(CNT_W)
    ) u_stall_counter (
        .clk_i  (clk),
        .rst_i  (reset),
        .en_i   (~pc_write & ~reset),
        .count_o(bus.stall_cycles)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three configurations share one stimulus stream and are
// compared against a bubble-debt reference model, a vector table and corner sequences.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, br, mem_req, mem_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) bus_a ();
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) bus_b ();
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(4))  bus_c ();

    assign bus_a.id_rs = id_rs; assign bus_a.id_rt = id_rt; assign bus_a.id_uses_rt = id_uses_rt;
    assign bus_a.ex_rt = ex_rt; assign bus_a.ex_memread = ex_memread;
    assign bus_a.ex_branch_taken = br; assign bus_a.mem_req = mem_req;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.id_rs = id_rs; assign bus_b.id_rt = id_rt; assign bus_b.id_uses_rt = id_uses_rt;
    assign bus_b.ex_rt = ex_rt; assign bus_b.ex_memread = ex_memread;
    assign bus_b.ex_branch_taken = br; assign bus_b.mem_req = mem_req;
    assign bus_b.mem_ready = mem_ready;
    assign bus_c.id_rs = id_rs; assign bus_c.id_rt = id_rt; assign bus_c.id_uses_rt = id_uses_rt;
    assign bus_c.ex_rt = ex_rt; assign bus_c.ex_memread = ex_memread;
    assign bus_c.ex_branch_taken = br; assign bus_c.mem_req = mem_req;
    assign bus_c.mem_ready = mem_ready;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .IGNORE_R0(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst), .bus(bus_a)
    );
    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .IGNORE_R0(1), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rst), .bus(bus_b)
    );
    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .IGNORE_R0(0), .CNT_W(4)) dut_c (
        .clk(clk), .reset(rst), .bus(bus_c)
    );

    // Outputs packed as {pc_write, ifid_write, ctrl_mux_sel, ifid_flush, idex_flush, exmem_write}
    logic [5:0]  act_o   [3];
    logic [1:0]  act_st  [3];
    logic [31:0] act_cnt [3];
    assign act_o[0] = {bus_a.pc_write, bus_a.ifid_write, bus_a.ctrl_mux_sel,
                       bus_a.ifid_flush, bus_a.idex_flush, bus_a.exmem_write};
    assign act_o[1] = {bus_b.pc_write, bus_b.ifid_write, bus_b.ctrl_mux_sel,
                       bus_b.ifid_flush, bus_b.idex_flush, bus_b.exmem_write};
    assign act_o[2] = {bus_c.pc_write, bus_c.ifid_write, bus_c.ctrl_mux_sel,
                       bus_c.ifid_flush, bus_c.idex_flush, bus_c.exmem_write};
    assign act_st[0] = bus_a.state_o;
    assign act_st[1] = bus_b.state_o;
    assign act_st[2] = bus_c.state_o;
    assign act_cnt[0] = 32'(bus_a.stall_cycles);
    assign act_cnt[1] = 32'(bus_b.stall_cycles);
    assign act_cnt[2] = 32'(bus_c.stall_cycles);

    localparam logic [5:0] O_DEF    = 6'b111001;
    localparam logic [5:0] O_BUBBLE = 6'b000001;
    localparam logic [5:0] O_FLUSH  = 6'b111111;
    localparam logic [5:0] O_FREEZE = 6'b001000;
    localparam logic [5:0] O_RESET  = 6'b000110;

    // Reference model: each configuration owes a number of bubbles; memory wait freezes all.
    int m_stalls [3] = '{1, 3, 1};
    int m_ign_r0 [3] = '{1, 1, 0};
    int m_cmax   [3] = '{65535, 65535, 15};
    int m_owed   [3];
    int m_state  [3];
    int m_cnt    [3];

    function automatic bit m_hz(int k);
        bit match;
        match = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
        return ex_memread && match && !(m_ign_r0[k] != 0 && ex_rt == 5'd0);
    endfunction

    function automatic logic [5:0] m_out(int k);
        if (rst) return O_RESET;
        if (mem_req && !mem_ready) return O_FREEZE;
        if (m_owed[k] > 0) return O_BUBBLE;
        if (br) return O_FLUSH;
        if (m_hz(k)) return O_BUBBLE;
        return O_DEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model outs dut%0d", k), 32'(act_o[k]), 32'(m_out(k)));
            chk($sformatf("model state dut%0d", k), 32'(act_st[k]), 32'(m_state[k]));
            chk($sformatf("model count dut%0d", k), act_cnt[k], 32'(m_cnt[k]));
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 3; k++) begin
            logic [5:0] o;
            bit mwv;
            o = m_out(k);
            mwv = mem_req && !mem_ready;
            if (rst) begin
                m_owed[k] = 0;
                m_cnt[k] = 0;
                m_state[k] = 0;
            end else begin
                if (!o[5] && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
                if (!mwv) begin
                    if (m_owed[k] > 0) m_owed[k]--;
                    else if (!br && m_hz(k)) m_owed[k] = m_stalls[k] - 1;
                end
                m_state[k] = mwv ? 2 : (m_owed[k] > 0 ? 1 : 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; ex_memread = 0;
        br = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        sample();
        advance();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rs, rt, ert;
        logic       uses, mrd, brt;
        logic [5:0] exp_a, exp_c;
    } vec_t;

    vec_t tbl [8];

    int         sq_req [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    int         sq_rdy [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [5:0] sq_out [8];
    int         sq_st  [8] = '{0, 1, 2, 2, 2, 2, 1, 0};

    initial begin
        tbl[0] = '{rs: 5, rt: 0, ert: 5, uses: 0, mrd: 1, brt: 0, exp_a: O_BUBBLE, exp_c: O_BUBBLE};
        tbl[1] = '{rs: 5, rt: 8, ert: 8, uses: 0, mrd: 1, brt: 0, exp_a: O_DEF,    exp_c: O_DEF};
        tbl[2] = '{rs: 5, rt: 8, ert: 8, uses: 1, mrd: 1, brt: 0, exp_a: O_BUBBLE, exp_c: O_BUBBLE};
        tbl[3] = '{rs: 0, rt: 3, ert: 0, uses: 0, mrd: 1, brt: 0, exp_a: O_DEF,    exp_c: O_BUBBLE};
        tbl[4] = '{rs: 5, rt: 3, ert: 5, uses: 1, mrd: 0, brt: 0, exp_a: O_DEF,    exp_c: O_DEF};
        tbl[5] = '{rs: 5, rt: 3, ert: 5, uses: 0, mrd: 1, brt: 1, exp_a: O_FLUSH,  exp_c: O_FLUSH};
        tbl[6] = '{rs: 3, rt: 0, ert: 0, uses: 1, mrd: 1, brt: 0, exp_a: O_DEF,    exp_c: O_BUBBLE};
        tbl[7] = '{rs: 1, rt: 2, ert: 3, uses: 1, mrd: 1, brt: 0, exp_a: O_DEF,    exp_c: O_DEF};
        sq_out = '{O_BUBBLE, O_FREEZE, O_FREEZE, O_FREEZE, O_FREEZE, O_BUBBLE, O_BUBBLE, O_DEF};

        rst = 1'b1;
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            m_owed[k] = 0; m_state[k] = 0; m_cnt[k] = 0;
        end
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            id_rs = tbl[i].rs; id_rt = tbl[i].rt; ex_rt = tbl[i].ert;
            id_uses_rt = tbl[i].uses; ex_memread = tbl[i].mrd; br = tbl[i].brt;
            sample();
            chk($sformatf("table %0d dut_a", i), 32'(act_o[0]), 32'(tbl[i].exp_a));
            chk($sformatf("table %0d dut_c", i), 32'(act_o[2]), 32'(tbl[i].exp_c));
            advance();
        end

        // Load-use on rt with 3 stalls, memory wait arriving during the second bubble.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            if (c == 0) begin
                ex_memread = 1; ex_rt = 8; id_rt = 8; id_uses_rt = 1; id_rs = 1;
            end
            mem_req = sq_req[c][0];
            mem_ready = sq_rdy[c][0];
            sample();
            chk($sformatf("memwait seq %0d outs", c), 32'(act_o[1]), 32'(sq_out[c]));
            chk($sformatf("memwait seq %0d state", c), 32'(act_st[1]), 32'(sq_st[c]));
            chk($sformatf("memwait seq %0d count", c), act_cnt[1], 32'(c));
            advance();
        end

        // Reset in the middle of a load stall.
        do_reset();
        clear_inputs();
        ex_memread = 1; ex_rt = 8; id_rs = 8;
        sample();
        chk("midreset hz state", 32'(act_st[1]), 32'(0));
        advance();
        clear_inputs();
        sample();
        chk("midreset lstall state", 32'(act_st[1]), 32'(1));
        chk("midreset lstall outs", 32'(act_o[1]), 32'(O_BUBBLE));
        advance();
        rst = 1'b1;
        sample();
        chk("midreset reset outs", 32'(act_o[1]), 32'(O_RESET));
        advance();
        rst = 1'b0;
        sample();
        chk("midreset after state", 32'(act_st[1]), 32'(0));
        chk("midreset after count", act_cnt[1], 32'(0));
        chk("midreset after outs", 32'(act_o[1]), 32'(O_DEF));
        advance();

        // 20 frozen cycles: the 4-bit counter pins at 15, the 16-bit one reaches 20.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int c = 0; c < 20; c++) begin
            sample();
            advance();
        end
        mem_req = 0;
        sample();
        chk("saturate cnt4", act_cnt[2], 32'(15));
        chk("saturate cnt16", act_cnt[1], 32'(20));
        chk("release outs", 32'(act_o[2]), 32'(O_DEF));
        advance();

        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_memread = ($urandom_range(0, 2) != 0);
            br = ($urandom_range(0, 9) == 0);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ready = 1'($urandom_range(0, 1));
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised pipeline hazard controller for the 5-stage MIPS core. Sits beside the IF/ID and ID/EX registers.
- Detects load-use hazards and stalls for a configurable number of cycles, not just one.
- Freezes the whole pipe while the data-memory handshake is pending, and flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5: register-specifier width.
- LOAD_USE_STALLS, 1: bubbles inserted per load-use hazard; legal range 1..4.
- IGNORE_R0, 1: when 1, a load targeting register 0 never causes a hazard.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_rs  in  REG_ADDR_W  rs of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch).
- ex_rt  in  REG_ADDR_W  destination rt of the instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  MEM stage has an outstanding data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ctrl_mux_sel  out  1  1 = pass ID control to ID/EX; 0 = inject bubble (zero control).
- ifid_flush  out  1  clear IF/ID.
- idex_flush  out  1  clear ID/EX.
- exmem_write  out  1  EX/MEM and MEM/WB enable.
- state_o  out  2  current FSM state, for debug.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0, excluding reset.

Behaviour:
- Reset: clk/reset as above. While reset=1, next state is RUN, cnt=0, stall_cycles=0. Outputs are held at pc_write=0, ifid_write=0, ctrl_mux_sel=0, ifid_flush=1, idex_flush=1, exmem_write=0. Reset mid-stall aborts the stall with no residue.
- Outputs are combinational from registered state plus current inputs. Detection acts in the same cycle it is seen.
- hz (load-use hit) = ex_memread & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)) & !(IGNORE_R0 & ex_rt==0).
- mw (memory wait) = mem_req & !mem_ready.
- Default (no event): pc_write=1, ifid_write=1, ctrl_mux_sel=1, exmem_write=1, flushes=0.
- Priority: reset > mw > ex_branch_taken > load stall.
- FSM states: RUN=0, LSTALL=1, MWAIT=2.
- RUN:
  - mw: freeze all (pc_write=ifid_write=exmem_write=0, ctrl_mux_sel=1, no flush); go to MWAIT.
  - else ex_branch_taken: ifid_flush=idex_flush=1, pc_write=1; stay in RUN. A pending hz is discarded.
  - else hz: pc_write=0, ifid_write=0, ctrl_mux_sel=0. If LOAD_USE_STALLS>1, load cnt=LOAD_USE_STALLS-1 and go to LSTALL; otherwise stay in RUN.
- LSTALL:
  - Outputs are as for hz regardless of the current ex_* inputs, since the load has moved on.
  - cnt decrements each cycle; at cnt==1 return to RUN.
  - mw during LSTALL: freeze, and cnt holds.
  - ex_branch_taken cannot occur in LSTALL, because EX holds a bubble.
- MWAIT:
  - Freeze while mw.
  - When mem_ready=1, return to the state saved on entry (RUN or LSTALL, with cnt preserved).
  - An ex_branch_taken held during the freeze is acted on in the first non-frozen cycle.
- stall_cycles: increments each non-reset cycle with pc_write=0; saturates at all-ones and does not wrap.
- mem_ready without mem_req is ignored.

Decomposition:
- Shared package: state encodings (RUN/LSTALL/MWAIT) and the bubble-select constant (CTRL_BUBBLE=0, CTRL_PASS=1) used by the ID/EX mux.
- One sub-module: hazard_stall_counter (saturating CNT_W counter with enable and synchronous reset).
- The FSM and detection logic stay in the top module.

Test Plan:
- Load-use on rs, LOAD_USE_STALLS=1: ex_memread=1, ex_rt=5, id_rs=5. Required: exactly one cycle of pc_write=0, ctrl_mux_sel=0; stall_cycles=1.
- Multi-cycle stall, LOAD_USE_STALLS=3, ex_rt=id_rt=8, id_uses_rt=1. Required: 3 consecutive bubble cycles, state_o 0→1→1→0, then back to default. With id_uses_rt=0 there is no stall.
- R0 and mixed cases: ex_rt=0=id_rs with IGNORE_R0=1 gives no stall; with IGNORE_R0=0 it gives a 1-cycle stall.
- Branch vs hazard in the same cycle: hz=1 and ex_branch_taken=1. Required: ifid_flush=idex_flush=1, pc_write=1, no bubble, state stays RUN.
- Memory wait inside a load stall, LOAD_USE_STALLS=3: assert mem_req=1, mem_ready=0 for 4 cycles during the 2nd bubble. Required: everything frozen for 4 cycles; 2 remaining bubbles after mem_ready; stall_cycles=7.
- Reset mid-LSTALL, and counter saturation: reset mid-LSTALL returns state_o=0 with counter 0. With CNT_W=4 and 20 stall cycles, stall_cycles saturates at 15.
